alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU, the next generation of the lab datapath's combinational 16-bit ALU. It adds a start/done handshake, registered result and status flags (Z, N, V), and an iterative shift-add multiply. It sits between the register-file read ports and the writeback mux. The controller FSM issues `start` and waits for `done` before writeback.

## Interface
- `WIDTH`, default 16: operand and result width in bits, minimum 4.
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request a new operation. Sampled only when `busy`=0.
- `ALUop` in 3: opcode, encoded as `alu_op_t`.
  - 000 ADD, 001 SUB, 010 AND, 011 NOTB, 100 MUL.
  - 101–111 are illegal.
- `Ain` in WIDTH: operand A, captured on accepted `start`.
- `Bin` in WIDTH: operand B, captured on accepted `start`.
- `out` out WIDTH: registered result.
- `Z` out 1: registered zero flag.
- `N` out 1: registered negative flag.
- `V` out 1: registered overflow flag.
- `busy` out 1: high while a multiply is iterating.
- `done` out 1: one-cycle pulse; `out`/`Z`/`N`/`V` are updated in that cycle.

## Operation
- States: IDLE, MUL.
- IDLE:
  - `start`=1 with a non-MUL op: compute combinationally, register `out` and flags, pulse `done`, stay in IDLE.
  - `start`=1 with MUL: capture `Ain`/`Bin`, clear the 2·WIDTH accumulator, load the iteration counter with WIDTH, go to MUL.
- MUL, each cycle:
  - If multiplier LSB=1, add the multiplicand to the accumulator.
  - Shift the multiplicand left and the multiplier right; decrement the counter.
  - When the counter reaches 0: register the result, pulse `done`, return to IDLE.
- Arithmetic rules:
  - ADD/SUB are two's complement modulo 2^WIDTH. V = signed overflow: operands of equal sign (ADD) or differing sign (SUB) where the result sign differs from `Ain`.
  - AND is bitwise `Ain & Bin`. NOTB is `~Bin`, with `Ain` ignored. V=0 for both.
  - MUL is unsigned. `out` = low WIDTH bits of the product. V=1 iff the upper WIDTH bits are nonzero.
  - Z = (`out`==0) and N = `out`[WIDTH-1], for all ops.
- Illegal opcode: `out`=0, Z=1, N=0, V=0, `done` pulses with single-cycle latency.
- Flags and `out` hold their value between `done` pulses. They are never updated mid-multiply.
- `start` while `busy`=1 is ignored. Operands and opcode are not re-captured.
- Reset (any time, including mid-MUL): abort the operation, go to IDLE.
  - Reset values: `out`=0, Z=0, N=0, V=0, `busy`=0, `done`=0.
  - No `done` is issued for the aborted op.

## Timing
- Single-cycle ops: `start` sampled at edge k; `done`=1 and the new `out`/flags become visible after edge k, for one cycle.
- MUL: `start` accepted at edge k.
  - `busy`=1 from edge k through edge k+WIDTH−1.
  - `done`=1 after edge k+WIDTH, i.e. latency WIDTH cycles; `busy` deasserts with `done`.
- Back-to-back: `start` may be asserted in the `done` cycle. It is accepted, giving one op per cycle for non-MUL ops.
- `done` is never asserted two consecutive cycles for one operation.
- No combinational path from inputs to outputs.

## Structure
- `alu_pkg` contains:
  - `alu_op_t` (3-bit enum).
  - `alu_state_t` (IDLE, MUL).
  - Opcode constants.
- One sub-module, `alu_comb`: parametrised combinational ADD/SUB/AND/NOTB datapath plus Z/N/V generation. `alu_mc` instantiates it and owns the FSM, multiply iteration and output registers.

## Test plan
- ADD 2+3, then SUB 7−2 (WIDTH=16) -> `out`=5, Z=0, N=0, V=0; `done` one cycle after each `start`. Back-to-back `start` in the `done` cycle is accepted.
- AND 8&7 -> `out`=0, Z=1. NOTB with `Bin`=8 -> `out`=16'hFFF7, N=1, Z=0.
- ADD 16'h7FFF+1 -> `out`=16'h8000, V=1, N=1. SUB 16'h8000−1 -> `out`=16'h7FFF, V=1.
- MUL 7×6 -> `out`=42, V=0. MUL 300×300 -> `out`=16'h5F90, V=1. For both, `done` arrives exactly 16 cycles after the accepting edge, and `busy` is high throughout.
- `start` ADD 1+1 while MUL is busy -> ignored; only the MUL `done` appears, with the MUL result.
- Assert `reset` mid-MUL -> `busy`=0, `done` never pulses, `out`=0 and Z=N=V=0. The next `start` ADD 4+6 -> `out`=10 after one cycle.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the multi-cycle ALU.
//               alu_op_t    - 3-bit opcode (ADD, SUB, AND, NOTB, MUL;
//                             codes 101-111 are illegal)
//               alu_state_t - controller state (IDLE, MUL)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] c_op_add  = 3'b000;
    localparam logic [2:0] c_op_sub  = 3'b001;
    localparam logic [2:0] c_op_and  = 3'b010;
    localparam logic [2:0] c_op_notb = 3'b011;
    localparam logic [2:0] c_op_mul  = 3'b100;

    typedef enum logic [2:0] {
        OP_ADD  = c_op_add,
        OP_SUB  = c_op_sub,
        OP_AND  = c_op_and,
        OP_NOTB = c_op_notb,
        OP_MUL  = c_op_mul
    } alu_op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Combinational single-cycle datapath (ADD, SUB, AND, NOTB)
//               with zero / negative / signed-overflow flag generation.
//               Any other opcode yields result 0, Z=1, N=0, V=0.
// Ports       : i_a, i_b   - operands
//               i_op       - opcode
//               o_result   - result
//               o_z/o_n/o_v- zero, negative, signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_t          i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_z,
    output logic             o_n,
    output logic             o_v
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_result = '0;
        o_v      = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum;
                // Same-sign operands whose sum flips sign
                o_v = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                // Differing-sign operands whose difference flips sign of A
                o_result = w_diff;
                o_v = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  o_result = i_a & i_b;
            OP_NOTB: o_result = ~i_b;
            default: o_result = '0;
        endcase
    end

    assign o_z = (o_result == '0);
    assign o_n = o_result[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU with start/done handshake. Single-cycle ops
//               complete one cycle after start; MUL is an iterative unsigned
//               shift-add taking WIDTH cycles. Result and flags are
//               registered and only change in the done cycle.
// Ports       : clk, reset      - clock, async active-high reset
//               start, ALUop    - request and opcode (sampled when !busy)
//               Ain, Bin        - operands
//               out, Z, N, V    - registered result and flags
//               busy            - multiply in progress
//               done            - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);

    alu_state_t         r_state;
    alu_state_t         w_next_state;

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0] r_cnt;

    logic [WIDTH-1:0]   r_out;
    logic               r_z;
    logic               r_n;
    logic               r_v;
    logic               r_done;

    alu_op_t            w_op;
    logic [WIDTH-1:0]   w_res;
    logic               w_z;
    logic               w_n;
    logic               w_v;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mul_last;

    assign w_op = alu_op_t'(ALUop);

    alu_comb #(
        .WIDTH    (WIDTH)
    ) u_alu_comb (
        .i_a      (Ain),
        .i_b      (Bin),
        .i_op     (w_op),
        .o_result (w_res),
        .o_z      (w_z),
        .o_n      (w_n),
        .o_v      (w_v)
    );

    // Partial-product add for the current multiplier LSB
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Counter at 1 means this cycle performs the final iteration
    assign w_mul_last = (r_cnt == c_cnt_w'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start && (w_op == OP_MUL)) w_next_state = MUL;
            MUL:     if (w_mul_last)                w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_op == OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, Ain};
                            r_mplier <= Bin;
                            r_acc    <= '0;
                            r_cnt    <= c_cnt_w'(WIDTH);
                        end else begin
                            r_out  <= w_res;
                            r_z    <= w_z;
                            r_n    <= w_n;
                            r_v    <= w_v;
                            r_done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - c_cnt_w'(1);
                    if (w_mul_last) begin
                        r_out  <= w_acc_next[WIDTH-1:0];
                        r_z    <= (w_acc_next[WIDTH-1:0] == '0);
                        r_n    <= w_acc_next[WIDTH-1];
                        r_v    <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out  = r_out;
    assign Z    = r_z;
    assign N    = r_n;
    assign V    = r_v;
    assign done = r_done;
    assign busy = (r_state == MUL);

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mc
// Description : Self-checking bench for alu_mc (WIDTH=16): table of
//               single-cycle vectors applied back-to-back, then directed
//               multiply, busy-ignore and mid-multiply reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] out;
    logic             Z;
    logic             N;
    logic             V;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic        z;
        logic        n;
        logic        v;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    alu_mc #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ALUop (ALUop),
        .Ain   (Ain),
        .Bin   (Bin),
        .out   (out),
        .Z     (Z),
        .N     (N),
        .V     (V),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // {done, out, Z, N, V}
    function automatic logic [31:0] pack_dut();
        return {12'd0, done, out, Z, N, V};
    endfunction

    function automatic logic [31:0] pack_exp(input logic d, input logic [15:0] o,
                                             input logic z, input logic n, input logic v);
        return {12'd0, d, o, z, n, v};
    endfunction

    // Issues a MUL at edge k, checks busy=1/done=0 after edges k..k+15,
    // done and result after edge k+16, then done low and result held.
    // When inject is set, an ADD 1+1 start is presented while busy.
    task automatic run_mul(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eo, input logic ez, input logic en,
                           input logic ev, input bit inject);
        int bad;
        bad = 0;
        @(negedge clk);
        start = 1'b1; ALUop = 3'b100; Ain = a; Bin = b;
        @(posedge clk); #1;
        for (int i = 0; i < WIDTH; i++) begin
            if (!busy || done) bad++;
            @(negedge clk);
            if (inject && (i == 3 || i == 4)) begin
                start = 1'b1; ALUop = 3'b000; Ain = 16'd1; Bin = 16'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        check({nm, "_busy_window"}, bad, 0);
        check({nm, "_done"}, {busy, pack_dut()}, {1'b0, pack_exp(1'b1, eo, ez, en, ev)});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({nm, "_hold"}, pack_dut(), pack_exp(1'b0, eo, ez, en, ev));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int saw_done;
        n_checks = 0;
        n_fail   = 0;

        //           op      A         B         out       z     n     v
        vecs[0]  = '{3'b000, 16'd2,    16'd3,    16'd5,    1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 16'd7,    16'd2,    16'd5,    1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b010, 16'd8,    16'd7,    16'd0,    1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b011, 16'h1234, 16'd8,    16'hFFF7, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'b000, 16'h7FFF, 16'd1,    16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{3'b001, 16'h8000, 16'd1,    16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{3'b001, 16'd3,    16'd5,    16'hFFFE, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'b000, 16'hFFFF, 16'd1,    16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 16'd5,    16'd5,    16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{3'b111, 16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; ALUop = 3'b000; Ain = '0; Bin = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {busy, pack_dut()}, {1'b0, pack_exp(1'b0, 16'd0, 1'b0, 1'b0, 1'b0)});
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {busy, pack_dut()}, {1'b0, pack_exp(1'b0, 16'd0, 1'b0, 1'b0, 1'b0)});

        // Back-to-back: next start is presented during the previous done cycle
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            start = 1'b1; ALUop = vecs[i].op; Ain = vecs[i].a; Bin = vecs[i].b;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), {busy, pack_dut()},
                  {1'b0, pack_exp(1'b1, vecs[i].out, vecs[i].z, vecs[i].n, vecs[i].v)});
        end
        @(negedge clk);
        start = 1'b0;
        Ain = 16'd9; Bin = 16'd9;
        @(posedge clk); #1;
        check("done_drops_and_hold", pack_dut(), pack_exp(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0));

        run_mul("mul_7x6",     16'd7,    16'd6,    16'd42,   1'b0, 1'b0, 1'b0, 1'b0);
        run_mul("mul_300x300", 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b0, 1'b1, 1'b0);
        run_mul("mul_ffff_sq", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        run_mul("mul_8000x1",  16'h8000, 16'd1,    16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_mul("mul_0",       16'd0,    16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_mul("mul_busy_ign",16'd13,   16'd11,   16'd143,  1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; ALUop = 3'b100; Ain = 16'd300; Bin = 16'd300;
        @(posedge clk); #1;
        check("mul_abort_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_mul", {busy, pack_dut()}, {1'b0, pack_exp(1'b0, 16'd0, 1'b0, 1'b0, 1'b0)});
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done++;
        end
        check("no_done_after_abort", saw_done, 0);

        @(negedge clk);
        start = 1'b1; ALUop = 3'b000; Ain = 16'd4; Bin = 16'd6;
        @(posedge clk); #1;
        check("add_after_abort", pack_dut(), pack_exp(1'b1, 16'd10, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("single_done_pulse", pack_dut(), pack_exp(1'b0, 16'd10, 1'b0, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
